// File: rtl/rrp_add_pkg.sv
// rrp_add_pkg: shared definitions for the redundant radix-r adder.
//   digit_bits() - bits per signed digit for a given radix
//   xfer_t       - 2-bit signed transfer digit {-1, 0, +1}
//   digit_t      - signed digit type for the default radix
package rrp_add_pkg;

  function automatic int digit_bits(input int radix);
    return $clog2(radix) + 1;
  endfunction

  typedef logic signed [1:0] xfer_t;

  localparam xfer_t XFER_POS  = 2'sb01;
  localparam xfer_t XFER_ZERO = 2'sb00;
  localparam xfer_t XFER_NEG  = 2'sb11;

  localparam int DEF_RADIX = 4;
  localparam int DIGIT_W   = digit_bits(DEF_RADIX);

  typedef logic signed [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/rrp_add_if.sv
// rrp_add_if: operand/result bus of the redundant adder.
//   x_in, y_in : WIDTH packed signed digits each (driven by master)
//   s_out      : WIDTH+1 packed signed digits (driven by slave)
interface rrp_add_if
  import rrp_add_pkg::*;
#(
  parameter int RADIX = 4,
  parameter int WIDTH = 6
);
  localparam int D = digit_bits(RADIX);
  localparam int N = D * WIDTH;

  logic [N-1:0]   x_in;
  logic [N-1:0]   y_in;
  logic [N+D-1:0] s_out;

  modport master (output x_in, output y_in, input s_out);
  modport slave  (input x_in, input y_in, output s_out);
endinterface

// File: rtl/rrp_add_digit.sv
// rrp_add_digit: one digit position of the carry-free adder.
//   x_i, y_i : input digits in [-(RADIX-1), RADIX-1]
//   t_in     : transfer from the digit below
//   t_out    : transfer to the digit above
//   s_i      : sum digit in [-(RADIX-1), RADIX-1]
module rrp_add_digit
  import rrp_add_pkg::*;
#(
  parameter int RADIX = 4
) (
  input  logic signed [digit_bits(RADIX)-1:0] x_i,
  input  logic signed [digit_bits(RADIX)-1:0] y_i,
  input  xfer_t                               t_in,
  output xfer_t                               t_out,
  output logic signed [digit_bits(RADIX)-1:0] s_i
);
  localparam int D = digit_bits(RADIX);
  localparam logic signed [D:0] A_POS = (D+1)'(RADIX - 1);
  localparam logic signed [D:0] A_NEG = -A_POS;
  localparam logic signed [D:0] RAD   = (D+1)'(RADIX);

  logic signed [D:0]   p;
  logic signed [D:0]   corr;
  logic signed [D-1:0] w;

  // Upper half: position sum, transfer decision and interim digit.
  // The interim digit lands in [-(a-1), a-1], so it fits in D bits.
  always_comb begin
    p     = {x_i[D-1], x_i} + {y_i[D-1], y_i};
    t_out = XFER_ZERO;
    corr  = '0;
    if (p >= A_POS) begin
      t_out = XFER_POS;
      corr  = RAD;
    end else if (p <= A_NEG) begin
      t_out = XFER_NEG;
      corr  = -RAD;
    end
    w = D'(p - corr);
  end

  // Lower half: absorb the incoming transfer.
  always_comb begin
    s_i = w + {{(D-2){t_in[1]}}, t_in};
  end

endmodule

// File: rtl/rrp_add.sv
// rrp_add: two-stage pipelined carry-free adder for radix-RADIX
// maximally-redundant signed-digit operands.
//   clock : rising-edge clock
//   reset : synchronous active-high, clears both pipeline stages
//   bus   : x_in/y_in operands in, s_out sum out (latency 2)
module rrp_add
  import rrp_add_pkg::*;
#(
  parameter int RADIX = 4,
  parameter int WIDTH = 6
) (
  input  logic      clock,
  input  logic      reset,
  rrp_add_if.slave  bus
);
  localparam int D = digit_bits(RADIX);
  localparam int N = D * WIDTH;

  logic [N-1:0]   x_d, x_q;
  logic [N-1:0]   y_d, y_q;
  logic [N+D-1:0] s_d, s_q;

  xfer_t          t_chain [WIDTH+1];
  logic [D-1:0]   s_dig   [WIDTH];

  always_comb begin
    x_d = bus.x_in;
    y_d = bus.y_in;
  end

  assign t_chain[0] = XFER_ZERO;

  for (genvar i = 0; i < WIDTH; i++) begin : g_digit
    rrp_add_digit #(.RADIX(RADIX)) u_digit (
      .x_i   (x_q[i*D +: D]),
      .y_i   (y_q[i*D +: D]),
      .t_in  (t_chain[i]),
      .t_out (t_chain[i+1]),
      .s_i   (s_dig[i])
    );
  end

  // Top digit is the last transfer, sign-extended to a full digit.
  always_comb begin
    s_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s_d[i*D +: D] = s_dig[i];
    end
    s_d[WIDTH*D +: D] = {{(D-2){t_chain[WIDTH][1]}}, t_chain[WIDTH]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
      s_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      s_q <= s_d;
    end
  end

  assign bus.s_out = s_q;

endmodule

// File: tb/tb_rrp_add.sv
module tb_rrp_add;
  import rrp_add_pkg::*;

  localparam int RADIX = 4;
  localparam int WIDTH = 6;
  localparam int D     = 3;
  localparam int N     = D * WIDTH;
  localparam int SW    = N + D;
  localparam int NRAND = 130;

  logic clock = 1'b0;
  logic reset = 1'b1;

  rrp_add_if #(.RADIX(RADIX), .WIDTH(WIDTH)) bus ();

  rrp_add #(.RADIX(RADIX), .WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int hx [NRAND][WIDTH];
  int hy [NRAND][WIDTH];

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] pack(input int dig [WIDTH]);
    logic [N-1:0] v = '0;
    for (int i = 0; i < WIDTH; i++) v[i*D +: D] = D'(dig[i]);
    return v;
  endfunction

  function automatic longint model_val(input int xd [WIDTH], input int yd [WIDTH]);
    longint v = 0;
    longint w = 1;
    for (int i = 0; i < WIDTH; i++) begin
      v += longint'(xd[i] + yd[i]) * w;
      w *= RADIX;
    end
    return v;
  endfunction

  function automatic longint sum_val(input logic [SW-1:0] s);
    longint v = 0;
    longint w = 1;
    digit_t dg;
    for (int i = 0; i <= WIDTH; i++) begin
      dg = s[i*D +: D];
      v += longint'(dg) * w;
      w *= RADIX;
    end
    return v;
  endfunction

  function automatic int bad_digits(input logic [SW-1:0] s);
    int n = 0;
    digit_t dg;
    for (int i = 0; i <= WIDTH; i++) begin
      dg = s[i*D +: D];
      if (dg < -3 || dg > 3) n++;
    end
    return n;
  endfunction

  task automatic rand_digits(output int dig [WIDTH]);
    for (int i = 0; i < WIDTH; i++) dig[i] = int'($urandom_range(0, 6)) - 3;
  endtask

  task automatic directed(input string tag, input int xd [WIDTH], input int yd [WIDTH],
                          input logic [SW-1:0] exp_bits, input longint exp_val);
    @(posedge clock); #1;
    bus.x_in = pack(xd);
    bus.y_in = pack(yd);
    @(posedge clock);
    @(posedge clock); #1;
    check({tag, "_bits"}, longint'(bus.s_out), longint'(exp_bits));
    check({tag, "_val"}, sum_val(bus.s_out), exp_val);
    check({tag, "_range"}, longint'(bad_digits(bus.s_out)), 0);
  endtask

  initial begin
    int xd [WIDTH];
    int yd [WIDTH];

    bus.x_in = '0;
    bus.y_in = '0;
    reset    = 1'b1;

    // Reset held for 3 edges with random inputs.
    for (int k = 0; k < 3; k++) begin
      rand_digits(xd); rand_digits(yd);
      bus.x_in = pack(xd);
      bus.y_in = pack(yd);
      @(posedge clock); #1;
      check("reset_hold", longint'(bus.s_out), 0);
    end
    rand_digits(xd); rand_digits(yd);
    bus.x_in = pack(xd);
    bus.y_in = pack(yd);
    reset = 1'b0;
    @(posedge clock); #1;
    check("reset_rel1", longint'(bus.s_out), 0);
    @(posedge clock); #1;
    check("reset_rel2", sum_val(bus.s_out), model_val(xd, yd));

    directed("zeros", '{0,0,0,0,0,0}, '{0,0,0,0,0,0}, 21'b0, 0);
    directed("maxpos", '{3,3,3,3,3,3}, '{3,3,3,3,3,3},
             21'b001_011_011_011_011_011_010, 8190);
    directed("maxneg", '{-3,-3,-3,-3,-3,-3}, '{-3,-3,-3,-3,-3,-3},
             21'b111_101_101_101_101_101_110, -8190);
    directed("xfer3", '{2,0,0,0,0,0}, '{1,0,0,0,0,0},
             21'b000_000_000_000_000_001_111, 3);
    directed("noxfer2", '{1,0,0,0,0,0}, '{1,0,0,0,0,0},
             21'b000_000_000_000_000_000_010, 2);

    // Back-to-back random vectors, one per clock.
    @(posedge clock); #1;
    for (int j = 0; j < NRAND + 2; j++) begin
      if (j >= 2) begin
        check("rand_val", sum_val(bus.s_out), model_val(hx[j-2], hy[j-2]));
        check("rand_range", longint'(bad_digits(bus.s_out)), 0);
      end
      if (j < NRAND) begin
        rand_digits(hx[j]); rand_digits(hy[j]);
        bus.x_in = pack(hx[j]);
        bus.y_in = pack(hy[j]);
      end
      @(posedge clock); #1;
    end

    // Mid-stream reset discards in-flight data.
    bus.x_in = pack('{3,3,3,3,3,3});
    bus.y_in = pack('{3,3,3,3,3,3});
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("mid_reset", longint'(bus.s_out), 0);
    reset = 1'b0;
    @(posedge clock); #1;
    check("mid_reset_flush", longint'(bus.s_out), 0);
    @(posedge clock); #1;
    check("mid_reset_resume", sum_val(bus.s_out), 8190);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
